// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment
// display. Display data is double buffered: a load lands in a shadow copy,
// and the shadow is promoted to the active copy only at the frame boundary,
// so a frame never mixes old and new data. Each digit slot begins with a
// blanking gap (all anodes off) so the cathode bus can settle between digits.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   value_in   in   32-bit display word; nibble k drives digit k
//   en_in      in   per-digit enable (0 = digit dark for its whole slot)
//   dp_in      in   per-digit decimal point (1 = lit)
//   lz_in      in   leading-zero suppression enable
//   load       in   one-cycle strobe capturing value_in/en_in/dp_in/lz_in
//   digit      out  nibble of the current digit, feeds the hex decoder
//   anode      out  active-low anode drive, at most one bit low
//   dp_n       out  active-low decimal point of the current digit
//   pending    out  a captured load is waiting for the frame boundary
//   frame_tick out  one-cycle pulse on the last cycle of the last slot
module seven_seg_scanner #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int NUM_DIGITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic [7:0]  en_in,
  input  logic [7:0]  dp_in,
  input  logic        lz_in,
  input  logic        load,
  output logic [3:0]  digit,
  output logic [7:0]  anode,
  output logic        dp_n,
  output logic        pending,
  output logic        frame_tick
);

  localparam int PW = $clog2(DIGIT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_CYCLES - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  en;
    logic [7:0]  dp;
    logic        lz;
  } disp_t;

  // A digit is visible when enabled and not a suppressed leading zero.
  // Scanning from the top digit down, upper_zero stays true while every
  // nibble from the top down to k is zero; digit 0 is always kept.
  function automatic logic [7:0] visible_mask(input disp_t d);
    logic [7:0] mask;
    logic       upper_zero;
    mask       = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero & (d.value[4*k +: 4] == 4'h0);
      mask[k]    = d.en[k] & ~(d.lz & upper_zero & (k != 0));
    end
    return mask;
  endfunction

  state_t          state, state_next;
  logic [PW-1:0]   presc, presc_next;
  logic [IW-1:0]   idx, idx_next;
  disp_t           shadow, shadow_next;
  disp_t           active, active_next;
  disp_t           incoming;
  logic            pending_next;
  logic            presc_wrap, frame_end;
  logic [7:0]      vis;
  logic [3:0]      digit_next;
  logic [7:0]      anode_next;
  logic            dp_n_next;
  logic            frame_tick_next;

  // Slot counters and next-state logic.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    presc_wrap = (presc == PRESC_LAST);
    frame_end  = presc_wrap && (idx == IDX_LAST);
    presc_next = presc_wrap ? '0 : presc + 1'b1;
    idx_next   = idx;
    if (presc_wrap) begin
      idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    state_next = state;
    case (state)
      BLANK:   if (presc_next == BLANK_END) state_next = SHOW;
      SHOW:    if (presc_wrap) state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // Double buffering. A load on the boundary cycle goes straight to the
  // active copy, so pending never rises for it.
  always_comb begin
    incoming     = {value_in, en_in, dp_in, lz_in};
    shadow_next  = shadow;
    active_next  = active;
    pending_next = pending;
    if (load) shadow_next = incoming;
    if (frame_end) begin
      pending_next = 1'b0;
      if (load)         active_next = incoming;
      else if (pending) active_next = shadow;
    end else if (load) begin
      pending_next = 1'b1;
    end
  end

  // Outputs are computed from the next-cycle state so they are registered
  // alongside state and idx. The nibble is presented in BLANK too, giving
  // the decoder the whole gap to settle.
  always_comb begin
    vis             = visible_mask(active_next);
    digit_next      = active_next.value[{idx_next, 2'b00} +: 4];
    anode_next      = '1;
    dp_n_next       = 1'b1;
    if (state_next == SHOW) begin
      anode_next[idx_next] = ~vis[idx_next];
      dp_n_next            = ~(active_next.dp[idx_next] & vis[idx_next]);
    end
    frame_tick_next = (presc_next == PRESC_LAST) && (idx_next == IDX_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      presc      <= '0;
      idx        <= '0;
      // NOTE: the data registers are cleared on reset as well, because the
      // display must stay dark until the first load after reset.
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      digit      <= 4'h0;
      anode      <= 8'hFF;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      presc      <= presc_next;
      idx        <= idx_next;
      shadow     <= shadow_next;
      active     <= active_next;
      pending    <= pending_next;
      digit      <= digit_next;
      anode      <= anode_next;
      dp_n       <= dp_n_next;
      frame_tick <= frame_tick_next;
    end
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexed scan controller for the 8-digit common-anode 7-segment display. The two 4-digit groups share one cathode bus, driven by anodes AN7..AN0.
- Holds a double-buffered 32-bit display word (8 nibbles) plus per-digit enable and decimal-point masks.
- Steps through the digits with an anti-ghost blanking gap between slots.
- Presents the current nibble on `digit`, which feeds the downstream hex-to-cathode decoder, and drives `anode` and `dp_n` directly.

Parameters:
- DIGIT_CYCLES, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 1000: leading cycles of each slot during which all anodes are off; must be at least 1.
- NUM_DIGITS, 8: digits scanned, range 1..8; index runs 0..NUM_DIGITS-1. Anode bits at or above NUM_DIGITS stay 1.

Ports:
- clk  in  1  system clock; all logic is clocked on the rising edge.
- rst  in  1  synchronous, active-high reset.
- value_in  in  32  nibble k = value_in[4k+3:4k] is displayed on digit k (AN k).
- en_in  in  8  per-digit enable; 0 keeps that anode off for the whole slot.
- dp_in  in  8  per-digit decimal point, 1 = lit.
- lz_in  in  1  leading-zero suppression enable.
- load  in  1  single-cycle strobe that captures value_in, en_in, dp_in and lz_in.
- digit  out  4  nibble for the current index; goes to the decoder.
- anode  out  8  active-low anode drive; at most one bit is 0 at any time.
- dp_n  out  1  active-low decimal point for the current index.
- pending  out  1  a captured load is waiting for the frame boundary.
- frame_tick  out  1  one-cycle pulse on the last cycle of the last slot.

Behaviour:
- Reset:
  - prescaler=0, idx=0, state=BLANK.
  - anode=8'hFF, digit=0, dp_n=1, pending=0, frame_tick=0.
  - Shadow and active registers cleared: value=0, en=0, dp=0, lz=0. The display is dark until the first load.
- All outputs are registered and update on the same edge as state and idx.
- Slot timing:
  - The prescaler counts 0..DIGIT_CYCLES-1, then wraps to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
- FSM with 2 states:
  - BLANK (prescaler < BLANK_CYCLES): anode=8'hFF, dp_n=1.
  - SHOW (remaining cycles of the slot): anode bit idx = ~visible(idx), all other bits 1; dp_n = ~(active_dp[idx] & visible(idx)).
  - Transition BLANK->SHOW when the prescaler reaches BLANK_CYCLES. Transition SHOW->BLANK on prescaler wrap.
- Output `digit`:
  - Equals active_value nibble[idx] in both states. It changes only at slot start, so the decoder settles during BLANK.
- Visibility:
  - visible(k) = active_en[k] & ~suppressed(k).
  - suppressed(k) is true when: active_lz=1, k>0, and nibbles k..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
- Double buffering:
  - load=1 copies the inputs to the shadow registers and sets pending=1.
  - frame_tick is asserted when idx=NUM_DIGITS-1 and prescaler=DIGIT_CYCLES-1.
  - On the frame_tick cycle with pending=1: active <= shadow and pending <= 0. The new data takes effect from slot 0 of the next frame, so no frame tears.
- Simultaneous events:
  - load on the frame_tick cycle: active <= the inputs present that cycle (bypass), and pending stays 0.
  - A second load before the boundary overwrites the shadow; last load wins.
  - Worst-case latency from load to visible output: NUM_DIGITS*DIGIT_CYCLES+1 cycles.
- Reset mid-scan takes effect on the next edge. It discards the shadow, the pending load and the active data.
- Anode invariant: all ones for at least BLANK_CYCLES between any two different active digits.

Test Plan:
Common setup: DIGIT_CYCLES=10, BLANK_CYCLES=2, NUM_DIGITS=8.
1. Reset -> anode=8'hFF and dp_n=1 at every cycle for 200 cycles. frame_tick pulses every 80 cycles, first at cycle 79 after reset release.
2. Load value_in=32'h89AB_CDEF, en_in=8'hFF, dp_in=8'h01, then wait for the boundary:
   - Next frame shows anode=8'hFE with digit=F and dp_n=0 in cycles 2..9 of slot 0.
   - Then 8'hFD with digit=E and dp_n=1, and so on through 8'h7F with digit=8.
   - anode=8'hFF in cycles 0..1 of every slot.
3. Load 32'h1111_1111 at cycle 35 of a frame showing 32'h2222_2222 -> the remainder of that frame shows 2 on every digit. pending=1 until frame_tick, then 0. The next frame shows 1.
4. Load asserted exactly on the frame_tick cycle -> the next slot 0 shows the new value and pending never rises.
5. Load value_in=32'h0000_0500, lz_in=1, en_in=8'hFF -> digits 7..3 stay dark (anode bit held 1). Digits 2, 1 and 0 light with 5, 0 and 0. With value 0, only digit 0 lights, showing 0.
6. Assert rst during the SHOW phase of digit 4 -> anode=8'hFF on the next edge, idx=0, pending=0, and the display stays dark until a new load.
